ola_trigger_match: RTL
======================

// Module: ola_trigger_match
// PURPOSE
//  Parametrised trigger stage for the logic-analyser sample path: a DEPTH-stage
//  valid/sample delay line plus a masked value/edge matcher with a hit counter.
//  Sits between sample capture and the trigger/storage controller. Samples pass
//  through unchanged; out_trigger marks the exact sample that fired the trigger.
// PARAMETERS
//  WIDTH   8   sample width in bits
//  DEPTH   2   pipeline latency in cycles, >=1
//  CWIDTH  16  hit-counter / cfg_count width
// PORTS
//  clock        in   1       sole clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  cfg_arm      in   1       1-cycle pulse: latch cfg_*, clear hits, enter ARMED
//  cfg_mask     in   WIDTH   bits taking part in compare
//  cfg_value    in   WIDTH   compare value
//  cfg_mode     in   2       0 level, 1 rise-into-match, 2 fall-out-of-match, 3 masked change
//  cfg_count    in   CWIDTH  events required to fire; 0 treated as 1
//  in_valid     in   1       sample qualifier
//  in_sample    in   WIDTH   sample data
//  out_valid    out  1       in_valid delayed DEPTH cycles
//  out_sample   out  WIDTH   in_sample delayed DEPTH cycles
//  out_trigger  out  1       high with out_valid on the firing sample only
//  out_armed    out  1       state==ARMED
//  out_fired    out  1       state==FIRED
// BEHAVIOUR
//  - Reset (async, reset_n=0): every pipeline stage, out_* =0, hits=0, state IDLE,
//    latched cfg =0, prev-valid flag =0. Applies mid-operation; pipeline flushed.
//  - Delay line: exactly DEPTH cycles in->out; bubbles (in_valid=0) preserved;
//    out_sample holds stage data regardless of out_valid.
//  - cfg_* used only via shadow registers loaded on cfg_arm; live changes ignored.
//  - Match m = ((in_sample & mask) == (value & mask)), evaluated on in_sample at
//    the input cycle. Only in_valid=1 cycles are evaluated and update history.
//  - History: prev_m, prev_s (masked sample), prev_ok. prev_ok cleared on arm; first
//    valid sample after arm only loads history (modes 1-3 no event; mode 0 may event).
//  - Event: mode0 m; mode1 m & !prev_m; mode2 !m & prev_m; mode3 masked sample != prev_s.
//  - FSM: IDLE -(cfg_arm)-> ARMED -(event & hits+1>=count)-> FIRED.
//    cfg_arm from any state -> ARMED, hits=0. FIRED/IDLE hold until cfg_arm.
//    ARMED event below count: hits<=hits+1 (never wraps; fires first).
//  - Firing: trigger flag enters stage 1 with that sample, travels with it; out_trigger
//    asserts exactly DEPTH cycles later together with out_valid=1. One pulse per arm.
//  - cfg_arm same cycle as in_valid: arm wins; that sample is not evaluated and does
//    not load history.
//  - Events in IDLE/FIRED update history only; no hits, no trigger.
//  - out_armed/out_fired registered from state (1 cycle after transition).
// STRUCTURE
//  - Package ola_trigger_pkg: MODE_LEVEL/MODE_RISE/MODE_FALL/MODE_CHANGE (2-bit),
//    state enc ST_IDLE=2'd0, ST_ARMED=2'd1, ST_FIRED=2'd2.
//  - Sub-module ola_trigger_delay #(WIDTH+1,DEPTH): async-low-reset shift line
//    carrying {valid, trigger, sample}; reused by later trigger stages.
//  - Top keeps shadow cfg, history, hit counter, FSM.
// TESTING
//  1 DEPTH=2, no arm: valid 0x5A at c0, bubble c1, 0x33 at c2 -> out 0x5A c2,
//    out_valid=0 c3, 0x33 c4; out_trigger never set.
//  2 mode0 mask F0 value A0 count1, arm; feed 1F,A3 -> out_trigger only with
//    out_sample A3; out_fired=1, out_armed=0; later A0 no pulse.
//  3 mode1 count3 mask FF value A0; feed A0,00,A0,00,A0,00,A0 -> first A0 loads
//    history only; fires on 4th A0 (3rd rise).
//  4 mode3 mask 0F: arm, feed 10,20,21 -> first two no event (masked equal), fires on 21;
//    mode2 value 55: 55,54 -> fires on 54.
//  5 cfg_arm same cycle as matching A0 (mode0 count1) -> no trigger; next A0 fires;
//    re-arm in FIRED -> ARMED, hits=0, fires again on next match.
//  6 reset_n low with valid data mid-pipeline -> out_* 0 immediately, state IDLE;
//    after release, outputs stay 0 until DEPTH cycles after new valid.

Source files
------------

// File: rtl/ola_trigger_pkg.sv
// Shared definitions for the logic-analyser trigger stages: compare modes,
// FSM state encoding and the per-sample event rule.
package ola_trigger_pkg;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_RISE   = 2'd1;
    localparam logic [1:0] MODE_FALL   = 2'd2;
    localparam logic [1:0] MODE_CHANGE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    // Edge modes need a valid history sample; level mode does not.
    function automatic logic eval_event(
        input logic [1:0] mode,
        input logic       m,
        input logic       prev_m,
        input logic       prev_ok,
        input logic       changed
    );
        logic evt;
        evt = 1'b0;
        case (mode)
            MODE_LEVEL:  evt = m;
            MODE_RISE:   evt = prev_ok & m & ~prev_m;
            MODE_FALL:   evt = prev_ok & ~m & prev_m;
            MODE_CHANGE: evt = prev_ok & changed;
            default:     evt = 1'b0;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/ola_trigger_delay.sv
// DEPTH-stage shift line carrying a valid qualifier alongside a data word;
// every stage is cleared by the asynchronous active-low reset.
module ola_trigger_delay #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_p;
    logic [WIDTH-1:0] data_p [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= in_valid;
            data_p[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_valid = vld_p[DEPTH-1];
    assign out_data  = data_p[DEPTH-1];

endmodule

// File: rtl/ola_trigger_match.sv
// Masked value/edge trigger matcher with hit counter; the firing flag rides the
// sample delay line so out_trigger lines up with the sample that caused it.
module ola_trigger_match
    import ola_trigger_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int CWIDTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_arm,
    input  logic [WIDTH-1:0]  cfg_mask,
    input  logic [WIDTH-1:0]  cfg_value,
    input  logic [1:0]        cfg_mode,
    input  logic [CWIDTH-1:0] cfg_count,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_sample,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_sample,
    output logic              out_trigger,
    output logic              out_armed,
    output logic              out_fired
);

    localparam logic [CWIDTH:0]   ONE_EXT = (CWIDTH+1)'(1);
    localparam logic [CWIDTH-1:0] ONE     = CWIDTH'(1);

    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  value_q;
    logic [1:0]        mode_q;
    logic [CWIDTH-1:0] count_q;
    logic              prev_m_q;
    logic [WIDTH-1:0]  prev_s_q;
    logic              prev_ok_q;
    logic [CWIDTH-1:0] hits_q;
    logic [CWIDTH-1:0] hits_d;
    state_t            state_q;
    state_t            state_d;
    logic              armed_q;
    logic              fired_q;

    logic [WIDTH-1:0]  masked;
    logic              m;
    logic              evt;
    logic              evaluate;
    logic [CWIDTH-1:0] count_eff;
    logic              reach;
    logic              fire;
    logic              trig_d;

    assign masked    = in_sample & mask_q;
    assign m         = (masked == (value_q & mask_q));
    assign evt       = eval_event(mode_q, m, prev_m_q, prev_ok_q, masked != prev_s_q);
    // An arm in the same cycle takes priority; that sample is neither evaluated nor recorded.
    assign evaluate  = in_valid & ~cfg_arm;
    assign count_eff = (count_q == '0) ? ONE : count_q;
    assign reach     = (({1'b0, hits_q} + ONE_EXT) >= {1'b0, count_eff});

    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        fire    = 1'b0;
        if (cfg_arm) begin
            state_d = ST_ARMED;
            hits_d  = '0;
        end else if (evaluate && evt && (state_q == ST_ARMED)) begin
            if (reach) begin
                fire    = 1'b1;
                state_d = ST_FIRED;
            end else begin
                hits_d = hits_q + ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hits_q    <= '0;
            armed_q   <= 1'b0;
            fired_q   <= 1'b0;
            mask_q    <= '0;
            value_q   <= '0;
            mode_q    <= '0;
            count_q   <= '0;
            prev_m_q  <= 1'b0;
            prev_s_q  <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hits_q  <= hits_d;
            armed_q <= (state_q == ST_ARMED);
            fired_q <= (state_q == ST_FIRED);
            if (cfg_arm) begin
                mask_q    <= cfg_mask;
                value_q   <= cfg_value;
                mode_q    <= cfg_mode;
                count_q   <= cfg_count;
                prev_ok_q <= 1'b0;
            end else if (in_valid) begin
                prev_m_q  <= m;
                prev_s_q  <= masked;
                prev_ok_q <= 1'b1;
            end
        end
    end

    // Stage boundary: sample and its trigger flag enter the DEPTH-cycle delay line together.
    ola_trigger_delay #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_delay (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   ({fire, in_sample}),
        .out_valid (out_valid),
        .out_data  ({trig_d, out_sample})
    );

    assign out_trigger = out_valid & trig_d;
    assign out_armed   = armed_q;
    assign out_fired   = fired_q;

endmodule
